in_fifo: RTL
============

Name: in_fifo

Overview:
- USB 2.0 full-speed IN FIFO, single clock domain: the transmit-direction counterpart of the OUT FIFO.
- The application pushes bytes through a valid/ready interface.
- On each IN token the SIE pulls one packet of at most IN_MAXPACKETSIZE bytes.
- Bytes are released from the FIFO only after the host ACKs; a repeated IN token without an ACK retransmits the identical packet.

Parameters:
- IN_MAXPACKETSIZE, 8: maximum bytes per IN packet (1..64).
- IN_DEPTH, 16: FIFO storage in bytes; must be >= IN_MAXPACKETSIZE; need not be a power of two.

Ports:
- clk_i  in  1  system clock, 12MHz*BIT_SAMPLES.
- rst_i  in  1  synchronous reset, active high.
- app_in_data_i  in  8  application byte.
- app_in_valid_i  in  1  app_in_data_i valid.
- app_in_ready_o  out  1  FIFO accepts a byte; the byte is written when valid&ready.
- in_empty_o  out  1  committed occupancy == 0.
- in_full_o  out  1  committed occupancy == IN_DEPTH.
- in_req_i  in  1  one-cycle pulse: IN token addressed to this endpoint.
- in_data_o  out  8  current packet byte.
- in_valid_o  out  1  in_data_o valid.
- in_ready_i  in  1  one-cycle pulse: the byte is consumed if in_valid_o=1; if in_valid_o=0 the packet ends.
- in_nak_o  out  1  registered; 1 = last IN token found the FIFO empty.
- in_ack_i  in  1  one-cycle pulse: host ACK received for the current packet.
- in_abort_i  in  1  one-cycle pulse: bus reset or timeout; the packet is dropped without commit.

Behaviour:

Reset (rst_i=1 at a clock edge):
- state=ST_IDLE; all pointers, counters and in_nak_o cleared.
- Outputs after reset: in_valid_o=0, in_empty_o=1, in_full_o=0, app_in_ready_o=1 (the first cycle after reset deasserts).
- Reset mid-packet discards all contents.

Storage and pointers:
- IN_DEPTH x 8 memory.
- wr_ptr: application write pointer.
- rd_ptr: committed read pointer.
- tx_ptr: speculative transmit pointer.
- Each pointer wraps IN_DEPTH-1 -> 0 explicitly.

Occupancy:
- occ_q, width clog2(IN_DEPTH+1), counts committed bytes.
- Update each cycle: occ_q += wr_fire; occ_q -= pkt_len_q on an ACK commit. Both in the same cycle gives occ_q + 1 - pkt_len_q.
- app_in_ready_o = (occ_q != IN_DEPTH), combinational from registers.
- A write is visible to in_valid_o on the next cycle.

State ST_IDLE:
- in_req_i && occ_q==0: in_nak_o<=1; stay in ST_IDLE.
- in_req_i && occ_q!=0: in_nak_o<=0; tx_ptr<=rd_ptr; cnt<=0; limit<=min(occ_q, IN_MAXPACKETSIZE); go to ST_DATA.

State ST_DATA:
- in_valid_o = (cnt < limit); in_data_o = mem[tx_ptr].
- Bytes written by the application during ST_DATA are never appended, because limit is frozen at the IN token.
- in_ready_i && in_valid_o: tx_ptr++, cnt++. in_valid_o/in_data_o stay stable until consumed.
- in_ready_i && !in_valid_o: pkt_len_q<=cnt; go to ST_WAIT_ACK.

State ST_WAIT_ACK:
- in_ack_i: rd_ptr<=rd_ptr+pkt_len_q (wrapped); occ_q reduced; go to ST_IDLE.
- in_req_i without a prior ACK (retry): tx_ptr<=rd_ptr; cnt<=0; limit<=pkt_len_q, so the same bytes and same length are resent; go to ST_DATA.

Abort and stray pulses:
- in_abort_i in any state: go to ST_IDLE; tx_ptr/cnt discarded; rd_ptr and occ_q unchanged. in_abort_i has priority over in_req_i/in_ack_i in the same cycle.
- in_ack_i outside ST_WAIT_ACK is ignored.
- in_req_i in ST_DATA is ignored.

Data integrity: the application can never overwrite uncommitted bytes, because full is computed from committed occupancy.

Decomposition:
- Shared package usb_cdc_pkg: state encodings ST_IN_IDLE/ST_IN_DATA/ST_IN_WAIT_ACK and the ceil_log2 function, shared with the OUT FIFO.
- One sub-module: in_fifo_ram, an IN_DEPTH x 8 register array with synchronous write and asynchronous read.
- Control logic stays in in_fifo.

Test Plan:
1. Reset; write 0x11,0x22,0x33; in_req_i -> in_data_o 0x11,0x22,0x33 on successive in_ready_i. Then in_ready_i with in_valid_o=0 -> ST_WAIT_ACK. in_ack_i -> in_empty_o=1.
2. Empty FIFO, in_req_i -> in_nak_o=1, in_valid_o stays 0. Write 0xA5, in_req_i -> in_nak_o=0, in_data_o=0xA5.
3. Write 10 bytes 0x00..0x09 with IN_MAXPACKETSIZE=8 -> first packet carries 0x00..0x07. After in_ack_i, the next packet carries 0x08,0x09 (length 2).
4. Retry: send a 3-byte packet with no in_ack_i, write 2 more bytes, in_req_i -> the identical 3 bytes are resent. After in_ack_i, occupancy=2.
5. Full/wrap: write 16 bytes -> in_full_o=1, app_in_ready_o=0. In the same cycle as the ACK of an 8-byte packet, the application write is held off. The next cycle app_in_ready_o=1, and the subsequent write wraps wr_ptr to 0 with data intact.
6. Mid-packet in_abort_i after 2 of 5 bytes -> ST_IDLE, occ_q=5. Next in_req_i restarts from the first byte. rst_i mid-packet -> in_empty_o=1, in_valid_o=0.

Source files
------------

// File: rtl/usb_cdc_pkg.sv
// Shared definitions for the USB CDC endpoint FIFOs.
// Holds the IN FIFO state encoding and a width helper.
package usb_cdc_pkg;

    typedef enum logic [1:0] {
        ST_IN_IDLE     = 2'd0,
        ST_IN_DATA     = 2'd1,
        ST_IN_WAIT_ACK = 2'd2
    } in_state_e;

    function automatic int ceil_log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/in_fifo_if.sv
// Application and SIE handshake signals of the IN FIFO.
// Names follow the FIFO's own point of view.
interface in_fifo_if;

    logic [7:0] app_in_data_i;
    logic       app_in_valid_i;
    logic       app_in_ready_o;
    logic       in_empty_o;
    logic       in_full_o;
    logic       in_req_i;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;
    logic       in_nak_o;
    logic       in_ack_i;
    logic       in_abort_i;

    modport slave (
        input  app_in_data_i, app_in_valid_i,
        input  in_req_i, in_ready_i, in_ack_i, in_abort_i,
        output app_in_ready_o, in_empty_o, in_full_o,
        output in_data_o, in_valid_o, in_nak_o
    );

    modport master (
        output app_in_data_i, app_in_valid_i,
        output in_req_i, in_ready_i, in_ack_i, in_abort_i,
        input  app_in_ready_o, in_empty_o, in_full_o,
        input  in_data_o, in_valid_o, in_nak_o
    );

endinterface

// File: rtl/in_fifo_ram.sv
// Byte storage for the IN FIFO.
// Synchronous write, asynchronous read.
module in_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    // Store the application byte on a write strobe.
    always_ff @(posedge clk_i) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/in_fifo.sv
// USB full-speed IN endpoint FIFO with ACK-gated commit.
// Packets are resent unchanged until the host acknowledges them.
module in_fifo
    import usb_cdc_pkg::*;
#(
    parameter int IN_MAXPACKETSIZE = 8,
    parameter int IN_DEPTH         = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    in_fifo_if.slave bus
);

    localparam int PW = ceil_log2(IN_DEPTH);
    localparam int OW = ceil_log2(IN_DEPTH + 1);
    localparam int CW = ceil_log2(IN_MAXPACKETSIZE + 1);

    localparam logic [OW-1:0] DEPTH_O = OW'(IN_DEPTH);
    localparam logic [OW-1:0] MPS_O   = OW'(IN_MAXPACKETSIZE);
    localparam logic [PW-1:0] LAST_P  = PW'(IN_DEPTH - 1);
    localparam logic [PW:0]   DEPTH_S = (PW+1)'(IN_DEPTH);

    in_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, tx_ptr_q;
    logic [OW-1:0] occ_q;
    logic [CW-1:0] cnt_q, limit_q, pkt_len_q;
    logic [CW-1:0] limit_new;
    logic          nak_q;
    logic          app_ready, wr_fire, tx_valid;
    logic          start, retry, consume, finish, commit, nak_set;
    logic [7:0]    rd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_add(
        input logic [PW-1:0] p,
        input logic [CW-1:0] n
    );
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= DEPTH_S) s = s - DEPTH_S;
        return s[PW-1:0];
    endfunction

    assign app_ready = (occ_q != DEPTH_O);
    assign wr_fire   = bus.app_in_valid_i & app_ready;
    assign tx_valid  = (state_q == ST_IN_DATA) && (cnt_q < limit_q);
    assign limit_new = (occ_q < MPS_O) ? CW'(occ_q)
                                       : CW'(IN_MAXPACKETSIZE);

    in_fifo_ram #(
        .DEPTH (IN_DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (bus.app_in_data_i),
        .raddr (tx_ptr_q),
        .rdata (rd_data)
    );

    // Packet state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IN_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and datapath strobes; abort wins over everything.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        retry   = 1'b0;
        consume = 1'b0;
        finish  = 1'b0;
        commit  = 1'b0;
        nak_set = 1'b0;
        if (bus.in_abort_i) begin
            state_d = ST_IN_IDLE;
        end else begin
            unique case (state_q)
                ST_IN_IDLE: begin
                    if (bus.in_req_i) begin
                        if (occ_q == '0) begin
                            nak_set = 1'b1;
                        end else begin
                            start   = 1'b1;
                            state_d = ST_IN_DATA;
                        end
                    end
                end
                ST_IN_DATA: begin
                    if (bus.in_ready_i) begin
                        if (tx_valid) begin
                            consume = 1'b1;
                        end else begin
                            finish  = 1'b1;
                            state_d = ST_IN_WAIT_ACK;
                        end
                    end
                end
                ST_IN_WAIT_ACK: begin
                    if (bus.in_ack_i) begin
                        commit  = 1'b1;
                        state_d = ST_IN_IDLE;
                    end else if (bus.in_req_i) begin
                        retry   = 1'b1;
                        state_d = ST_IN_DATA;
                    end
                end
                default: state_d = ST_IN_IDLE;
            endcase
        end
    end

    // Pointers, occupancy and packet bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tx_ptr_q  <= '0;
            occ_q     <= '0;
            cnt_q     <= '0;
            limit_q   <= '0;
            pkt_len_q <= '0;
            nak_q     <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (commit)  rd_ptr_q <= ptr_add(rd_ptr_q, pkt_len_q);
            if (start || retry) begin
                tx_ptr_q <= rd_ptr_q;
                cnt_q    <= '0;
                limit_q  <= start ? limit_new : pkt_len_q;
            end else if (consume) begin
                tx_ptr_q <= ptr_inc(tx_ptr_q);
                cnt_q    <= cnt_q + CW'(1);
            end
            if (finish) pkt_len_q <= cnt_q;
            occ_q <= occ_q + OW'(wr_fire)
                   - (commit ? OW'(pkt_len_q) : OW'(0));
            if (nak_set)    nak_q <= 1'b1;
            else if (start) nak_q <= 1'b0;
        end
    end

    assign bus.app_in_ready_o = app_ready;
    assign bus.in_empty_o     = (occ_q == '0);
    assign bus.in_full_o      = (occ_q == DEPTH_O);
    assign bus.in_data_o      = rd_data;
    assign bus.in_valid_o     = tx_valid;
    assign bus.in_nak_o       = nak_q;

endmodule
